// File: rtl/br_unit_if.sv
// Bus bundle between the control FSM / datapath and the branch unit.
// The master side issues requests and PC controls; the slave side (br_unit)
// returns the PC, status pulses and the taken-branch counter.
interface br_unit_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [15:0]      ir;
   logic             ld_pc;
   logic [15:0]      pc_in;
   logic             inc_pc;
   logic             br_enable;
   logic [2:0]       nzp_out;
   logic [15:0]      pc;
   logic             busy;
   logic             done;
   logic             taken;
   logic [CNT_W-1:0] br_count;

   modport master (
      output start, ir, ld_pc, pc_in, inc_pc, br_enable,
      input  nzp_out, pc, busy, done, taken, br_count
   );

   modport slave (
      input  start, ir, ld_pc, pc_in, inc_pc, br_enable,
      output nzp_out, pc, busy, done, taken, br_count
   );
endinterface

// File: rtl/br_unit.sv
// Branch unit: owns the program counter, evaluates BR instructions through
// an external nzp comparator and counts taken branches (saturating).
// IDLE -> EVAL -> (TAKE) -> DONE -> IDLE; PC controls only act in IDLE.
module br_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 8
) (
   input logic      Clk,
   input logic      Reset,
   br_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      TAKE = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [15:0]      ir_q, ir_d;
   logic             took_q, took_d;
   logic [CNT_W-1:0] br_count_q, br_count_d;
   logic [15:0]      offset_sext;
   logic             unused_ir;

   // Opcode bits are latched with the rest of the word but never decoded here.
   assign unused_ir   = ^ir_q[15:12];
   assign offset_sext = {{7{ir_q[8]}}, ir_q[8:0]};

   // State register; reset aborts any branch in flight.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: branch decision is taken from br_enable while in EVAL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = EVAL;
         EVAL:    state_d = bus.br_enable ? TAKE : DONE;
         TAKE:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded from registered state only, so no input-to-output path.
   always_comb begin
      bus.busy  = (state_q != IDLE);
      bus.done  = (state_q == DONE);
      bus.taken = (state_q == DONE) && took_q;
   end

   // Datapath next values: start outranks ld_pc outranks inc_pc, all idle-only.
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      took_d     = took_q;
      br_count_d = br_count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ir_d   = bus.ir;
               took_d = 1'b0;
            end else if (bus.ld_pc) begin
               pc_d = bus.pc_in;
            end else if (bus.inc_pc) begin
               pc_d = pc_q + 16'd1;
            end
         end
         TAKE: begin
            pc_d   = pc_q + offset_sext;
            took_d = 1'b1;
            if (br_count_q != {CNT_W{1'b1}})
               br_count_d = br_count_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= 16'h0000;
         took_q     <= 1'b0;
         br_count_q <= '0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         took_q     <= took_d;
         br_count_q <= br_count_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.nzp_out  = ir_q[11:9];
   assign bus.br_count = br_count_q;
endmodule

// File: tb/tb_br_unit.sv
// Directed bench for br_unit with a done-driven scoreboard.
module tb_br_unit;
   localparam int          CNT_W    = 2;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   br_unit_if #(.CNT_W(CNT_W)) bus ();

   br_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0]      pc;
      logic             taken;
      logic [CNT_W-1:0] cnt;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending branch.
   always @(negedge Clk) begin
      exp_t e;
      if (bus.done) begin
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done: got done=1 pc=%h required no pending branch", bus.pc);
         end else begin
            e = sb.pop_front();
            $display("branch done: pc=%h taken=%0b count=%0d cycle=%0d", bus.pc, bus.taken, bus.br_count, cyc);
            chk("done_pc", bus.pc, e.pc);
            chk("done_taken", bus.taken, e.taken);
            chk("done_count", bus.br_count, e.cnt);
            chk("done_latency_cycle", cyc, e.cyc);
         end
      end else if (bus.taken) begin
         chk("taken_without_done", bus.taken, 1'b0);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 10) begin
         @(negedge Clk);
         n++;
      end
      chk("idle_timeout", bus.busy, 1'b0);
   endtask

   task automatic load_pc(input logic [15:0] v);
      @(negedge Clk);
      bus.ld_pc = 1'b1;
      bus.pc_in = v;
      @(negedge Clk);
      bus.ld_pc = 1'b0;
      chk("load_pc", bus.pc, v);
   endtask

   task automatic branch(input logic [15:0] ir, input logic be, input logic [15:0] epc,
                         input logic et, input logic [CNT_W-1:0] ecnt);
      exp_t e;
      @(negedge Clk);
      bus.start     = 1'b1;
      bus.ir        = ir;
      bus.br_enable = be;
      e.pc = epc; e.taken = et; e.cnt = ecnt; e.cyc = cyc + (et ? 3 : 2);
      sb.push_back(e);
      @(negedge Clk);
      bus.start = 1'b0;
      chk("nzp_out_eval", bus.nzp_out, ir[11:9]);
      chk("busy_eval", bus.busy, 1'b1);
      wait_idle();
   endtask

   initial begin
      bus.start = 0; bus.ir = 0; bus.ld_pc = 0; bus.pc_in = 0;
      bus.inc_pc = 0; bus.br_enable = 0;

      // Asynchronous reset, checked before any clock edge.
      #2 Reset = 1'b0;
      #1;
      chk("rst_pc", bus.pc, RESET_PC);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_taken", bus.taken, 1'b0);
      chk("rst_count", bus.br_count, 0);
      chk("rst_nzp", bus.nzp_out, 3'b000);
      @(negedge Clk);
      Reset = 1'b1;

      // Three fetch increments.
      bus.inc_pc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("inc_busy", bus.busy, 1'b0);
      end
      bus.inc_pc = 1'b0;
      chk("inc_pc3", bus.pc, 16'h0003);

      // Taken branch, offset +5.
      load_pc(16'h3000);
      branch(16'h0E05, 1'b1, 16'h3005, 1'b1, 2'd1);

      // Offset -2: not taken, then taken.
      load_pc(16'h3000);
      branch(16'h05FE, 1'b0, 16'h3000, 1'b0, 2'd1);
      branch(16'h05FE, 1'b1, 16'h2FFE, 1'b1, 2'd2);

      // PC wrap both ways.
      load_pc(16'hFFFF);
      @(negedge Clk); bus.inc_pc = 1'b1;
      @(negedge Clk); bus.inc_pc = 1'b0;
      chk("inc_wrap", bus.pc, 16'h0000);
      load_pc(16'h0001);
      branch(16'h05FE, 1'b1, 16'hFFFF, 1'b1, 2'd3);

      // start beats ld_pc/inc_pc; controls ignored while busy.
      load_pc(16'h1234);
      begin
         exp_t e;
         @(negedge Clk);
         bus.start = 1'b1; bus.ld_pc = 1'b1; bus.inc_pc = 1'b1;
         bus.pc_in = 16'h5555; bus.ir = 16'h0000; bus.br_enable = 1'b0;
         e.pc = 16'h1234; e.taken = 1'b0; e.cnt = 2'd3; e.cyc = cyc + 2;
         sb.push_back(e);
         @(negedge Clk);
         chk("prio_pc", bus.pc, 16'h1234);
         chk("prio_busy", bus.busy, 1'b1);
         @(negedge Clk);
         chk("busy_ignore_pc", bus.pc, 16'h1234);
         bus.start = 1'b0; bus.ld_pc = 1'b0; bus.inc_pc = 1'b0;
         wait_idle();
         chk("after_ignore_pc", bus.pc, 16'h1234);
      end

      // nzp=000 follows br_enable; counter saturates at 3.
      branch(16'h0003, 1'b1, 16'h1237, 1'b1, 2'd3);
      branch(16'h0E01, 1'b1, 16'h1238, 1'b1, 2'd3);

      // Reset during TAKE aborts with no PC update and no done.
      load_pc(16'h4000);
      @(negedge Clk);
      bus.start = 1'b1; bus.ir = 16'h0E10; bus.br_enable = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      @(negedge Clk);
      chk("take_busy", bus.busy, 1'b1);
      #2 Reset = 1'b0;
      #1;
      chk("abort_pc", bus.pc, RESET_PC);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_count", bus.br_count, 0);
      chk("abort_nzp", bus.nzp_out, 3'b000);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (4) @(negedge Clk);
      chk("post_abort_pc", bus.pc, RESET_PC);
      chk("post_abort_busy", bus.busy, 1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/br_unit.md
BR_UNIT -- requirements
Module: br_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 8, width of the taken-branch counter.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request from the control FSM: current IR is a BR instruction.
REQ-006 ir  input  16  instruction word; [11:9] is the nzp field, [8:0] is the signed offset9.
REQ-007 ld_pc  input  1  load pc_in into PC (JMP/bus path).
REQ-008 pc_in  input  16  external PC value.
REQ-009 inc_pc  input  1  fetch increment, PC <= PC + 1.
REQ-010 br_enable  input  1  branch decision from the downstream nzp comparator.
REQ-011 nzp_out  output  3  latched ir[11:9] driven to the comparator's nzp input.
REQ-012 pc  output  16  current program counter.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at branch completion.
REQ-015 taken  output  1  one-cycle pulse, coincident with done, when the branch was taken.
REQ-016 br_count  output  CNT_W  number of taken branches since reset.

Function
REQ-017 The FSM SHALL have four states: IDLE, EVAL, TAKE, DONE.
REQ-018 IDLE with start=1: latch ir into ir_q and go to EVAL.
REQ-019 IDLE with start=0: stay in IDLE.
REQ-020 nzp_out SHALL equal ir_q[11:9] at all times, so br_enable is valid throughout EVAL.
REQ-021 EVAL: sample br_enable; if 1, go to TAKE, else go to DONE.
REQ-022 TAKE: PC <= PC + SEXT16(ir_q[8:0]); br_count increments; go to DONE.
REQ-023 DONE: assert done=1, and taken=1 if TAKE was visited; return to IDLE.
REQ-024 Latency from start to done SHALL be 3 cycles when taken and 2 cycles when not taken.
REQ-025 PC priority in IDLE SHALL be: start (PC unchanged) > ld_pc > inc_pc.
REQ-026 ld_pc, inc_pc and start received while busy=1 SHALL be ignored, with no queuing.
REQ-027 PC arithmetic SHALL be modulo 2^16: 16'hFFFF + 1 = 16'h0000, and offset wrap is the same.
REQ-028 Sign extension SHALL replicate ir_q[8]; offset range is -256..+255.
REQ-029 br_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 The nzp field 3'b000 SHALL follow br_enable like any other value; this block applies no special case.
REQ-031 done and taken SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-032 Reset=0 SHALL immediately, without waiting for Clk, force: state IDLE, pc=RESET_PC, ir_q=0 (nzp_out=3'b000), busy=0, done=0, taken=0, br_count=0.
REQ-033 Reset asserted mid-branch (EVAL or TAKE) SHALL abort the branch, with no PC update and no done pulse.
REQ-034 After Reset deasserts, the first state change SHALL occur on the next posedge Clk.

Verification
REQ-035 Reset, then inc_pc for 3 cycles -> pc=16'h0003; busy=0 throughout.
REQ-036 pc=16'h3000, start with ir=16'h0E05, br_enable=1 in EVAL -> nzp_out=3'b111; 3 cycles later pc=16'h3005, done=taken=1 for one cycle, br_count=1.
REQ-037 pc=16'h3000, start with ir=16'h05FE (offset -2), br_enable=0 -> done after 2 cycles, taken=0, pc=16'h3000; then repeat with br_enable=1 -> pc=16'h2FFE.
REQ-038 pc=16'hFFFF, inc_pc -> 16'h0000; pc=16'h0001 with offset -2 taken -> 16'hFFFF.
REQ-039 start, ld_pc and inc_pc together in IDLE -> pc unchanged and FSM enters EVAL; ld_pc pulsed during EVAL -> ignored.
REQ-040 Reset pulsed low during TAKE -> pc=RESET_PC immediately, state IDLE, no done pulse; CNT_W=2 with 5 taken branches -> br_count=3.
